next_pc_ras: RTL and testbench

- Parametrised fetch-address unit; successor of the combinational next-PC logic.
- Owns the PC register and resolves redirects with fixed priority: stall, then branch, then JR, then J/JAL, then sequential.
- Adds a return-address stack (RAS) that predicts `jr $ra` at fetch, so a correct prediction needs no flush.
- Sits between the IF stage (instruction memory address) and the ID/EX pipeline registers (flush controls).

---
 rtl/next_pc_ras_pkg.sv | 16 +
 rtl/next_pc_ras_stack.sv | 47 ++++
 rtl/next_pc_ras.sv | 114 +++++++++++
 tb/tb_next_pc_ras.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/next_pc_ras_pkg.sv
// Shared ISA constants and fetch-decode types for the next-PC / return-address-stack unit.
package next_pc_ras_pkg;

    localparam logic [5:0] OPC_SPECIAL = 6'd0;
    localparam logic [5:0] OPC_J       = 6'd2;
    localparam logic [5:0] OPC_JAL     = 6'd3;
    localparam logic [5:0] FUN_JR      = 6'd8;
    localparam logic [4:0] REG_RA      = 5'd31;

    typedef struct packed {
        logic is_j;
        logic is_jal;
        logic is_ret;
    } fetch_dec_t;

endpackage

// File: rtl/next_pc_ras_stack.sv
// Circular return-address stack: overwrites the oldest entry when full,
// and a simultaneous push+pop replaces the top entry in place.
module ras_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            pushData,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  wr_idx;

    // ptr is the next free slot; it wraps naturally because RAS_DEPTH is a power of two
    assign top_idx = ptr - 1'b1;
    assign wr_idx  = pop ? top_idx : ptr;
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !pop) begin
            ptr <= ptr + 1'b1;
            if (count != CNT_W'(RAS_DEPTH))
                count <= count + 1'b1;
        end else if (pop && !push) begin
            ptr   <= top_idx;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_idx] <= pushData;
    end

endmodule

// File: rtl/next_pc_ras.sv
// Fetch-address unit with a speculative return-address stack predicting `jr $ra`.
// Define NEXT_PC_RAS_STATS_EN to add saturating redirect / RAS hit / RAS miss counters.
module next_pc_ras
    import next_pc_ras_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                RAS_DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'('h3000)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 instruction,
    input  logic                        stall,
    input  logic                        taken,
    input  logic [ADDR_W-1:0]           branchAddr,
    input  logic                        isJumpReg,
    input  logic [ADDR_W-1:0]           jumpRegAddr,
    input  logic                        jrPredictedIn,
    input  logic [ADDR_W-1:0]           jrPredAddrIn,
    output logic [ADDR_W-1:0]           pc,
    output logic                        jrPredicted,
    output logic [ADDR_W-1:0]           jrPredAddr,
    output logic                        flushID,
    output logic                        flushEX,
    output logic [$clog2(RAS_DEPTH):0]  rasCount
`ifdef NEXT_PC_RAS_STATS_EN
    ,
    output logic [31:0]                 statRedirects,
    output logic [31:0]                 statRasHits,
    output logic [31:0]                 statRasMisses
`endif
);
    logic [ADDR_W-1:0] next_addr, jump_addr, new_pc, ras_top;
    logic              jr_match, jr_hit, jr_miss, ras_push, ras_pop;
    fetch_dec_t        dec;
    logic              unused_insn;

    assign next_addr = pc + ADDR_W'(4);
    assign jump_addr = {next_addr[ADDR_W-1:28], instruction[25:0], 2'b00};

    assign dec.is_j   = instruction[31:26] == OPC_J;
    assign dec.is_jal = instruction[31:26] == OPC_JAL;
    assign dec.is_ret = instruction[31:26] == OPC_SPECIAL && instruction[5:0] == FUN_JR
                        && instruction[25:21] == REG_RA;
    assign unused_insn = ^instruction[20:6];

    assign jr_match = jrPredAddrIn == jumpRegAddr;
    assign jr_hit   = isJumpReg && jrPredictedIn && jr_match;
    assign jr_miss  = isJumpReg && !jr_hit;

    always_comb begin
        new_pc      = next_addr;
        flushID     = 1'b0;
        flushEX     = 1'b0;
        jrPredicted = 1'b0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        if (stall) begin
            new_pc  = pc;
            flushEX = 1'b1;
        end else if (taken) begin
            new_pc  = branchAddr;
            flushID = 1'b1;
            flushEX = 1'b1;
        end else if (jr_miss) begin
            new_pc  = jumpRegAddr;
            flushID = 1'b1;
            flushEX = 1'b1;
        end else if (dec.is_j || dec.is_jal) begin
            new_pc   = jump_addr;
            ras_push = dec.is_jal;
        end else if (dec.is_ret && rasCount != '0) begin
            new_pc      = ras_top;
            jrPredicted = 1'b1;
            ras_pop     = 1'b1;
        end
    end

    // Prediction address is only meaningful when jrPredicted is set
    assign jrPredAddr = ras_top;

    always_ff @(posedge clk) begin
        if (reset) pc <= RESET_VECTOR;
        else       pc <= new_pc;
    end

    ras_stack #(.RAS_DEPTH(RAS_DEPTH), .ADDR_W(ADDR_W)) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .pushData (next_addr),
        .top      (ras_top),
        .count    (rasCount)
    );

`ifdef NEXT_PC_RAS_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            statRedirects <= '0;
            statRasHits   <= '0;
            statRasMisses <= '0;
        end else if (!stall) begin
            if ((taken || jr_miss) && ~&statRedirects)
                statRedirects <= statRedirects + 32'd1;
            if (jr_hit && ~&statRasHits)
                statRasHits <= statRasHits + 32'd1;
            if (isJumpReg && jrPredictedIn && !jr_match && ~&statRasMisses)
                statRasMisses <= statRasMisses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_next_pc_ras.sv
// Directed and randomized bench for next_pc_ras against a queue-based fetch model.
module tb_next_pc_ras;
    localparam logic [31:0] RV = 32'h0000_3000;

    logic        clk, reset, stall, taken, isJumpReg, jrPredictedIn;
    logic [31:0] instruction, branchAddr, jumpRegAddr, jrPredAddrIn;
    logic [31:0] pc, jrPredAddr;
    logic        jrPredicted, flushID, flushEX;
    logic [2:0]  rasCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc = 32'd0;
    logic [31:0] ras_q[$];
    logic        obs_jp, obs_fid, obs_fex;
    logic [31:0] obs_jpa;

    next_pc_ras dut (
        .clk(clk), .reset(reset), .instruction(instruction), .stall(stall),
        .taken(taken), .branchAddr(branchAddr), .isJumpReg(isJumpReg),
        .jumpRegAddr(jumpRegAddr), .jrPredictedIn(jrPredictedIn),
        .jrPredAddrIn(jrPredAddrIn), .pc(pc), .jrPredicted(jrPredicted),
        .jrPredAddr(jrPredAddr), .flushID(flushID), .flushEX(flushEX),
        .rasCount(rasCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] jal(input logic [25:0] idx);
        return {6'd3, idx};
    endfunction
    function automatic logic [31:0] jmp(input logic [25:0] idx);
        return {6'd2, idx};
    endfunction
    function automatic logic [31:0] jr(input logic [4:0] rs);
        return {6'd0, rs, 15'd0, 6'd8};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; taken = 1'b0; isJumpReg = 1'b0; jrPredictedIn = 1'b0;
        instruction = 32'd0; branchAddr = 32'd0; jumpRegAddr = 32'd0; jrPredAddrIn = 32'd0;
    endtask

    // One clock: predict from the rules, check combinational outputs, clock, check state.
    task automatic step();
        logic [31:0] nxt, npc;
        logic is_j, is_jal, is_ret, hit, e_fid, e_fex, e_jp, do_push, do_pop;
        nxt    = m_pc + 32'd4;
        is_jal = instruction[31:26] == 6'd3;
        is_j   = instruction[31:26] == 6'd2;
        is_ret = instruction[31:26] == 6'd0 && instruction[5:0] == 6'd8 && instruction[25:21] == 5'd31;
        hit    = isJumpReg && jrPredictedIn && (jrPredAddrIn == jumpRegAddr);
        e_fid = 0; e_fex = 0; e_jp = 0; do_push = 0; do_pop = 0; npc = nxt;
        if (stall) begin
            npc = m_pc; e_fex = 1;
        end else if (taken) begin
            npc = branchAddr; e_fid = 1; e_fex = 1;
        end else if (isJumpReg && !hit) begin
            npc = jumpRegAddr; e_fid = 1; e_fex = 1;
        end else if (is_j || is_jal) begin
            npc = {nxt[31:28], instruction[25:0], 2'b00}; do_push = is_jal;
        end else if (is_ret && ras_q.size() != 0) begin
            npc = ras_q[$]; e_jp = 1; do_pop = 1;
        end
        #1;
        obs_jp = jrPredicted; obs_jpa = jrPredAddr; obs_fid = flushID; obs_fex = flushEX;
        chk("flushID", flushID, e_fid);
        chk("flushEX", flushEX, e_fex);
        chk("jrPredicted", jrPredicted, e_jp);
        if (e_jp) chk("jrPredAddr", jrPredAddr, ras_q[$]);
        @(posedge clk); #1;
        if (reset) begin
            m_pc = RV;
            ras_q.delete();
        end else begin
            m_pc = npc;
            if (do_push) begin
                if (ras_q.size() == 4) void'(ras_q.pop_front());
                ras_q.push_back(nxt);
            end
            if (do_pop) void'(ras_q.pop_back());
        end
        chk("pc", pc, m_pc);
        chk("rasCount", rasCount, ras_q.size());
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; step(); reset = 1'b0;
    endtask

    initial begin
        logic [31:0] ret_exp [4];
        logic [25:0] ridx;
        ret_exp = '{32'h1034, 32'h1024, 32'h1014, 32'h1004};
        idle();

        // reset held two cycles with a JAL at fetch
        reset = 1'b1; instruction = jal(26'h100);
        repeat (2) begin
            step();
            chk("rst_pc", pc, RV); chk("rst_cnt", rasCount, 0);
            chk("rst_fid", obs_fid, 0); chk("rst_fex", obs_fex, 0);
        end
        reset = 1'b0; instruction = 32'd0;
        step(); chk("rel_pc", pc, 32'h3004);

        // correct return prediction
        do_reset();
        instruction = jal(26'h100);
        step(); chk("call_pc", pc, 32'h400); chk("call_cnt", rasCount, 1);
        instruction = jr(5'd31);
        step(); chk("ret_jp", obs_jp, 1); chk("ret_jpa", obs_jpa, 32'h3004);
        chk("ret_pc", pc, 32'h3004); chk("ret_cnt", rasCount, 0);
        idle(); isJumpReg = 1; jrPredictedIn = 1; jrPredAddrIn = 32'h3004; jumpRegAddr = 32'h3004;
        step(); chk("hit_fid", obs_fid, 0); chk("hit_fex", obs_fex, 0); chk("hit_pc", pc, 32'h3008);

        // mispredicted return
        jumpRegAddr = 32'h5000;
        step(); chk("miss_pc", pc, 32'h5000); chk("miss_fid", obs_fid, 1); chk("miss_fex", obs_fex, 1);

        // overflow: five nested calls, five returns
        do_reset();
        for (int i = 0; i < 5; i++) begin
            instruction = jal(26'h400 + 26'(i * 4));
            step();
        end
        chk("ovf_cnt", rasCount, 4);
        for (int i = 0; i < 5; i++) begin
            instruction = jr(5'd31);
            step();
            if (i < 4) begin
                chk("ovf_jp", obs_jp, 1); chk("ovf_jpa", obs_jpa, ret_exp[i]);
            end else begin
                chk("ovf_last_jp", obs_jp, 0); chk("ovf_last_pc", pc, 32'h1008);
            end
        end

        // priority: stall over taken over JAL
        do_reset();
        instruction = jal(26'h100); stall = 1; taken = 1; branchAddr = 32'h3100;
        step(); chk("pri_pc", pc, 32'h3000); chk("pri_fex", obs_fex, 1);
        chk("pri_fid", obs_fid, 0); chk("pri_cnt", rasCount, 0);
        stall = 0;
        step(); chk("br_pc", pc, 32'h3100); chk("br_fid", obs_fid, 1);
        chk("br_fex", obs_fex, 1); chk("br_cnt", rasCount, 0);

        // return with an empty stack
        do_reset();
        instruction = jr(5'd31);
        step(); chk("empty_jp", obs_jp, 0); chk("empty_pc", pc, 32'h3004);
        idle(); isJumpReg = 1; jumpRegAddr = 32'h3abc;
        step(); chk("empty_res_pc", pc, 32'h3abc); chk("empty_res_fid", obs_fid, 1);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 500; n++) begin
            idle();
            ridx = 26'($urandom);
            case ($urandom_range(0, 5))
                0: instruction = jal(ridx);
                1: instruction = jmp(ridx);
                2, 3: instruction = jr(5'd31);
                4: instruction = jr(5'd5);
                default: instruction = $urandom;
            endcase
            stall = ($urandom_range(0, 7) == 0);
            taken = ($urandom_range(0, 7) == 0);
            branchAddr = $urandom & 32'hffff_fffc;
            isJumpReg = ($urandom_range(0, 3) == 0);
            jrPredictedIn = 1'($urandom);
            jumpRegAddr = $urandom & 32'hffff_fffc;
            jrPredAddrIn = $urandom_range(0, 1) ? jumpRegAddr : ($urandom & 32'hffff_fffc);
            reset = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
